pc_sequencer: RTL

//   Next-PC controller for the 5-stage pipeline. Each cycle it arbitrates among sequential fetch, jr,

---
 rtl/pc_sequencer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Next-PC select for the 5-stage pipeline (sequential, jr, branch, exception) plus IF/ID, ID/EX flush control.
// pc_next/pc_we/flushes are same-cycle combinational; redirects blocked by imem_busy are parked in HOLD, never dropped.
module pc_sequencer #(
    parameter logic [31:0] RESET_VEC    = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC      = 32'h0000_4180,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_pc_cur,
    input  logic        i_stall_ld,
    input  logic        i_imem_busy,
    input  logic        i_jr_req,
    input  logic [31:0] i_jr_target,
    input  logic        i_br_req,
    input  logic [31:0] i_br_target,
    input  logic        i_exc_req,
    input  logic [31:0] i_exc_epc,
    output logic [31:0] o_pc_next,
    output logic        o_pc_we,
    output logic        o_flush_ifid,
    output logic        o_flush_idex,
    output logic [31:0] o_epc_out,
    output logic [15:0] o_redir_cnt
);
    typedef enum logic [1:0] {S_BOOT, S_RUN, S_HOLD, S_DRAIN} state_t;

    localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYCLES - 1);

    state_t      r_state;
    logic        r_pend_v;
    logic [31:0] r_pend_tgt;
    logic [2:0]  r_drain_cnt;
    logic [31:0] r_epc;
    logic [15:0] r_redir_cnt;

    logic        w_take_exc;
    logic        w_redirect;
    logic        w_latch;
    logic        w_cnt_inc;
    logic [31:0] w_target;

    always_comb begin
        o_pc_next    = i_pc_cur;
        o_pc_we      = 1'b0;
        o_flush_ifid = 1'b0;
        o_flush_idex = 1'b0;
        w_take_exc   = 1'b0;
        w_redirect   = 1'b0;
        w_latch      = 1'b0;
        w_cnt_inc    = 1'b0;
        w_target     = r_pend_tgt;
        if (i_reset) begin
            o_pc_next    = RESET_VEC;
            o_flush_ifid = 1'b1;
            o_flush_idex = 1'b1;
        end else begin
            case (r_state)
                S_BOOT: begin
                    o_pc_next    = RESET_VEC;
                    o_pc_we      = 1'b1;
                    o_flush_ifid = 1'b1;
                    o_flush_idex = 1'b1;
                end
                S_RUN: begin
                    if (i_exc_req) begin
                        w_take_exc = 1'b1;
                    end else if (i_br_req) begin
                        w_redirect   = 1'b1;
                        w_target     = i_br_target;
                        o_flush_ifid = 1'b1;
                        o_flush_idex = 1'b1;
                    end else if (i_jr_req && !i_stall_ld) begin
                        w_redirect   = 1'b1;
                        w_target     = i_jr_target;
                        o_flush_ifid = 1'b1;
                    end else if (!i_stall_ld && !i_imem_busy) begin
                        o_pc_next = i_pc_cur + 32'd4;
                        o_pc_we   = 1'b1;
                    end
                end
                S_HOLD: begin
                    // A newer EX correction replaces the parked target; jr is from a squashed path.
                    if (i_exc_req) begin
                        w_take_exc = 1'b1;
                    end else begin
                        if (i_br_req) begin
                            w_target     = i_br_target;
                            o_flush_ifid = 1'b1;
                            o_flush_idex = 1'b1;
                        end
                        if (i_imem_busy) begin
                            w_latch = i_br_req;
                        end else if (r_pend_v) begin
                            w_redirect = 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    o_flush_ifid = 1'b1;
                    o_flush_idex = 1'b1;
                    if (r_drain_cnt == 3'd0) begin
                        o_pc_next = EXC_VEC;
                        o_pc_we   = 1'b1;
                        w_cnt_inc = 1'b1;
                    end
                end
                default: ;
            endcase
            if (w_take_exc) begin
                o_flush_ifid = 1'b1;
                o_flush_idex = 1'b1;
            end
            if (w_redirect) begin
                if (i_imem_busy) begin
                    w_latch = 1'b1;
                end else begin
                    o_pc_next = w_target;
                    o_pc_we   = 1'b1;
                    w_cnt_inc = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_BOOT;
            r_pend_v    <= 1'b0;
            r_pend_tgt  <= '0;
            r_drain_cnt <= '0;
            r_epc       <= '0;
            r_redir_cnt <= '0;
        end else begin
            if (w_cnt_inc && r_redir_cnt != 16'hFFFF)
                r_redir_cnt <= r_redir_cnt + 16'd1;
            if (w_latch) begin
                r_pend_v   <= 1'b1;
                r_pend_tgt <= w_target;
            end
            if (w_take_exc) begin
                r_state     <= S_DRAIN;
                r_epc       <= i_exc_epc;
                r_drain_cnt <= DRAIN_INIT;
                r_pend_v    <= 1'b0;
            end else begin
                case (r_state)
                    S_BOOT:  r_state <= S_RUN;
                    S_RUN:   if (w_latch) r_state <= S_HOLD;
                    S_HOLD: begin
                        if (o_pc_we) begin
                            r_state  <= S_RUN;
                            r_pend_v <= 1'b0;
                        end
                    end
                    S_DRAIN: begin
                        if (r_drain_cnt == 3'd0)
                            r_state <= S_RUN;
                        else
                            r_drain_cnt <= r_drain_cnt - 3'd1;
                    end
                    default: r_state <= S_BOOT;
                endcase
            end
        end
    end

    assign o_epc_out   = r_epc;
    assign o_redir_cnt = r_redir_cnt;
endmodule
